// File: rtl/q2_pkg.sv
// Purpose: shared state enum, idle drive value and step-select helper for the q2 stimulus driver.
// Latency: none (declarations only).
// Backpressure: none.
package q2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } q2_state_t;

    // Value driven on {A,B} whenever no step is being played.
    localparam logic [1:0] AB_IDLE = 2'b00;

    // Widest step vector the helper accepts; callers size-cast their vector
    // into this width, so DEPTH is limited to 256 steps.
    localparam int STEP_VEC_W = 512;

    // Returns the 2-bit step at index idx (bits [2*idx+1:2*idx]).
    function automatic logic [1:0] step_sel(input logic [STEP_VEC_W-1:0] vec,
                                            input int unsigned           idx);
        logic [STEP_VEC_W-1:0] w_sh;
        w_sh = vec >> (2 * idx);
        return w_sh[1:0];
    endfunction

endpackage

// File: rtl/q2_stim_capture.sv
// Purpose: counts edges after run acceptance and captures {X,Z} SAMPLE_LAT edges after each step into resp.
// Latency: step i captured at accept edge + i + SAMPLE_LAT; o_final is combinational for that final edge.
// Backpressure: none; captures free-run once accepted. Optional compare logic under Q2_STIM_CHECK_EN.
module q2_stim_capture
    import q2_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int SAMPLE_LAT = 2,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_accept,
    input  logic [LW-1:0]        i_len,
    input  logic                 i_x,
    input  logic                 i_z,
`ifdef Q2_STIM_CHECK_EN
    input  logic [2*DEPTH-1:0]   i_expected,
    output logic                 o_mismatch,
    output logic [LW-1:0]        o_err_idx,
`endif
    output logic [2*DEPTH-1:0]   o_resp,
    output logic                 o_final
);

    // Counter must reach DEPTH-1+SAMPLE_LAT, the edge of the last capture.
    localparam int CW = $clog2(DEPTH + SAMPLE_LAT + 1);

    logic               r_active;
    logic [CW-1:0]      r_cnt;
    logic [LW-1:0]      r_len;
    logic [2*DEPTH-1:0] r_resp;

    logic [CW-1:0]      w_edge_n;
    logic [CW-1:0]      w_cap_idx;
    logic               w_cap_vld;
    logic               w_cap_wr;

    // Map the current edge (counted from acceptance) onto the step index it captures.
    always_comb begin
        w_edge_n  = r_cnt + CW'(1);
        w_cap_vld = r_active && (w_edge_n >= CW'(SAMPLE_LAT));
        w_cap_idx = w_edge_n - CW'(SAMPLE_LAT);
        w_cap_wr  = w_cap_vld && (w_cap_idx < CW'(r_len));
        o_final   = w_cap_vld && (w_cap_idx == (CW'(r_len) - CW'(1)));
    end

    // Capture counter and response register; cleared on acceptance, frozen after the final capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_len    <= '0;
            r_resp   <= '0;
        end else if (i_accept) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_len    <= i_len;
            r_resp   <= '0;
        end else if (r_active) begin
            r_cnt <= w_edge_n;
            if (o_final) begin
                r_active <= 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cap_wr && (w_cap_idx == CW'(i))) begin
                    r_resp[2*i +: 2] <= {i_x, i_z};
                end
            end
        end
    end

    assign o_resp = r_resp;

`ifdef Q2_STIM_CHECK_EN
    logic [2*DEPTH-1:0] r_exp;
    logic               r_mismatch;
    logic [LW-1:0]      r_err_idx;
    logic [1:0]         w_exp_step;

    // Expected step for the index being captured this edge.
    always_comb begin
        w_exp_step = step_sel(STEP_VEC_W'(r_exp), 32'(w_cap_idx));
    end

    // Sticky mismatch flag; err_idx keeps the first failing step only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp      <= '0;
            r_mismatch <= 1'b0;
            r_err_idx  <= '0;
        end else if (i_accept) begin
            r_exp      <= i_expected;
            r_mismatch <= 1'b0;
            r_err_idx  <= '0;
        end else if (w_cap_wr && ({i_x, i_z} != w_exp_step)) begin
            r_mismatch <= 1'b1;
            if (!r_mismatch) begin
                r_err_idx <= LW'(w_cap_idx);
            end
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_err_idx  = r_err_idx;
`endif

endmodule

// File: rtl/q2_stim_driver.sv
// Purpose: plays a latched A/B step sequence into q2 one step per clock and captures X/Z into resp; optional compare via Q2_STIM_CHECK_EN.
// Latency: done rises len-1+SAMPLE_LAT cycles after the start-accept edge; A/B are registered.
// Backpressure: start is honoured only in IDLE with 1<=len<=DEPTH; otherwise ignored, no queuing.
module q2_stim_driver
    import q2_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int SAMPLE_LAT = 2,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic [2*DEPTH-1:0]   pattern,
    output logic                 A,
    output logic                 B,
    input  logic                 X,
    input  logic                 Z,
    output logic                 busy,
    output logic                 done,
`ifdef Q2_STIM_CHECK_EN
    input  logic [2*DEPTH-1:0]   expected,
    output logic                 mismatch,
    output logic [LW-1:0]        err_idx,
`endif
    output logic [2*DEPTH-1:0]   resp
);

    q2_state_t          r_state;
    logic [2*DEPTH-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_step;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last_step;
    logic               w_final;

    // Accept decode and end-of-sequence detect for the drive path.
    always_comb begin
        w_accept    = (r_state == ST_IDLE) && start &&
                      (len != '0) && (len <= LW'(DEPTH));
        w_last_step = (r_step == (r_len - LW'(1)));
    end

    // Run FSM with registered A/B, busy and done. The final capture edge wins over
    // the RUN->DRAIN step so SAMPLE_LAT=1 goes straight from RUN to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pat   <= '0;
            r_len   <= '0;
            r_step  <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_pat      <= pattern;
                        r_len      <= len;
                        r_step     <= '0;
                        {r_a, r_b} <= step_sel(STEP_VEC_W'(pattern), 32'd0);
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_final) begin
                        {r_a, r_b} <= AB_IDLE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= ST_DONE;
                    end else if (w_last_step) begin
                        {r_a, r_b} <= AB_IDLE;
                        r_state    <= ST_DRAIN;
                    end else begin
                        r_step     <= r_step + LW'(1);
                        {r_a, r_b} <= step_sel(STEP_VEC_W'(r_pat), 32'(r_step + LW'(1)));
                    end
                end
                ST_DRAIN: begin
                    {r_a, r_b} <= AB_IDLE;
                    if (w_final) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign A    = r_a;
    assign B    = r_b;
    assign busy = r_busy;
    assign done = r_done;

    q2_stim_capture #(
        .DEPTH      (DEPTH),
        .SAMPLE_LAT (SAMPLE_LAT)
    ) u_capture (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_accept   (w_accept),
        .i_len      (len),
        .i_x        (X),
        .i_z        (Z),
`ifdef Q2_STIM_CHECK_EN
        .i_expected (expected),
        .o_mismatch (mismatch),
        .o_err_idx  (err_idx),
`endif
        .o_resp     (resp),
        .o_final    (w_final)
    );

endmodule

// File: tb/tb_q2_stim_driver.sv
// Purpose: directed self-checking bench for q2_stim_driver with a combinational (SAMPLE_LAT=1) and a registered (SAMPLE_LAT=2) loopback.
// Latency: expectations are queued when a run is launched and popped as steps, done and resp appear.
// Backpressure: every wait for done is bounded; an expired bound counts as a failure.
module tb_q2_stim_driver;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int PW    = 2 * DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       start_v;
    logic [LW-1:0]    len_v  [2];
    logic [PW-1:0]    pat_v  [2];
    logic [1:0]       a_v, b_v, x_v, z_v, busy_v, done_v;
    logic [PW-1:0]    resp_v [2];
    logic [1:0]       zkill;
`ifdef Q2_STIM_CHECK_EN
    logic [PW-1:0]    exp_v  [2];
    logic [1:0]       mm_v;
    logic [LW-1:0]    ei_v   [2];
`endif

    // Device 0: combinational loopback, X=A, Z=B (Z can be forced low).
    assign x_v[0] = a_v[0];
    assign z_v[0] = b_v[0] & ~zkill[0];

    // Device 1: loopback through one register stage.
    logic xr, zr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr <= 1'b0;
            zr <= 1'b0;
        end else begin
            xr <= a_v[1];
            zr <= b_v[1] & ~zkill[1];
        end
    end
    assign x_v[1] = xr;
    assign z_v[1] = zr;

    q2_stim_driver #(.DEPTH(DEPTH), .SAMPLE_LAT(1)) u_comb (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .len(len_v[0]), .pattern(pat_v[0]),
        .A(a_v[0]), .B(b_v[0]), .X(x_v[0]), .Z(z_v[0]),
        .busy(busy_v[0]), .done(done_v[0]),
`ifdef Q2_STIM_CHECK_EN
        .expected(exp_v[0]), .mismatch(mm_v[0]), .err_idx(ei_v[0]),
`endif
        .resp(resp_v[0])
    );

    q2_stim_driver #(.DEPTH(DEPTH), .SAMPLE_LAT(2)) u_reg (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .len(len_v[1]), .pattern(pat_v[1]),
        .A(a_v[1]), .B(b_v[1]), .X(x_v[1]), .Z(z_v[1]),
        .busy(busy_v[1]), .done(done_v[1]),
`ifdef Q2_STIM_CHECK_EN
        .expected(exp_v[1]), .mismatch(mm_v[1]), .err_idx(ei_v[1]),
`endif
        .resp(resp_v[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0]    q_ab   [$];
    logic [PW-1:0] q_resp [$];
    int            q_lat  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sample_lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [PW-1:0] len_mask(input int ln);
        logic [PW-1:0] m;
        m = '0;
        for (int i = 0; i < ln; i++) m[2*i +: 2] = 2'b11;
        return m;
    endfunction

    // Launch one run on device d, follow it step by step and check done/resp against the model.
    task automatic run(input int d, input logic [LW-1:0] ln, input logic [PW-1:0] pat, input bit hold);
        int            cyc;
        bit            seen;
        logic [1:0]    e_ab;
        logic [PW-1:0] er;
        logic [PW-1:0] zmask;
        int            el;
`ifdef Q2_STIM_CHECK_EN
        logic          em;
        logic [LW-1:0] eidx;
        logic [PW-1:0] ps;
        logic [PW-1:0] rs;
`endif
        zmask = zkill[d] ? 8'hAA : 8'hFF;
        for (int i = 0; i < int'(ln); i++) q_ab.push_back(pat[2*i +: 2]);
        q_resp.push_back(pat & len_mask(int'(ln)) & zmask);
        q_lat.push_back(int'(ln) - 1 + sample_lat(d));

        len_v[d]   = ln;
        pat_v[d]   = pat;
`ifdef Q2_STIM_CHECK_EN
        exp_v[d]   = pat;
`endif
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_v[d] = 1'b0;
        // Later changes to the inputs must not disturb the latched run.
        pat_v[d] = ~pat;
        len_v[d] = LW'(1);
`ifdef Q2_STIM_CHECK_EN
        exp_v[d] = ~pat;
`endif
        check("busy_on", 32'(busy_v[d]), 32'd1);
        check("resp_clr", 32'(resp_v[d]), 32'd0);

        cyc = 0;
        for (int i = 0; i < int'(ln); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
                cyc++;
            end
            e_ab = q_ab.pop_front();
            check("ab_step", 32'({a_v[d], b_v[d]}), 32'(e_ab));
        end

        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done_v[d]) seen = 1'b1;
            else check("ab_drain", 32'({a_v[d], b_v[d]}), 32'd0);
        end
        if (hold) start_v[d] = 1'b0;

        el = q_lat.pop_front();
        check("done_lat", seen ? cyc : -1, el);
        er = q_resp.pop_front();
        check("resp", 32'(resp_v[d]), 32'(er));
        check("busy_off", 32'(busy_v[d]), 32'd0);
`ifdef Q2_STIM_CHECK_EN
        em = 1'b0;
        eidx = '0;
        ps = pat;
        rs = er;
        for (int i = 0; i < int'(ln); i++) begin
            if (!em && (rs[2*i +: 2] != ps[2*i +: 2])) begin
                em = 1'b1;
                eidx = LW'(i);
            end
        end
        check("mismatch", 32'(mm_v[d]), 32'(em));
        check("err_idx", 32'(ei_v[d]), 32'(eidx));
`endif
        @(posedge clk); #1;
        check("done_pulse_end", 32'(done_v[d]), 32'd0);
        check("resp_hold", 32'(resp_v[d]), 32'(er));
        if (hold) begin
            @(posedge clk); #1;
            check("no_rerun", 32'(busy_v[d]), 32'd0);
        end
    endtask

    // A start with an out-of-range length must leave the device idle.
    task automatic ignored(input int d, input logic [LW-1:0] ln);
        len_v[d]   = ln;
        pat_v[d]   = 8'hFF;
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        check("ign_busy", 32'(busy_v[d]), 32'd0);
        @(posedge clk); #1;
        check("ign_busy2", 32'(busy_v[d]), 32'd0);
        check("ign_ab", 32'({a_v[d], b_v[d]}), 32'd0);
        check("ign_done", 32'(done_v[d]), 32'd0);
    endtask

    initial begin
        start_v = '0;
        zkill   = '0;
        for (int d = 0; d < 2; d++) begin
            len_v[d] = '0;
            pat_v[d] = '0;
`ifdef Q2_STIM_CHECK_EN
            exp_v[d] = '0;
`endif
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_ab", 32'({a_v[d], b_v[d]}), 32'd0);
            check("rst_busy", 32'(busy_v[d]), 32'd0);
            check("rst_done", 32'(done_v[d]), 32'd0);
            check("rst_resp", 32'(resp_v[d]), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run(0, 3'd4, 8'h2D, 1'b0);
        run(1, 3'd4, 8'h2D, 1'b0);
        run(1, 3'd1, 8'h03, 1'b0);
        ignored(1, 3'd0);
        ignored(1, 3'd5);
        run(0, 3'd3, 8'hE4, 1'b1);
        run(0, 3'd4, 8'hB1, 1'b0);
        run(1, 3'd4, 8'h96, 1'b0);
        run(0, 3'd2, 8'hFF, 1'b0);

        // Reset in the middle of a run: outputs clear without a clock edge.
        len_v[0]   = 3'd4;
        pat_v[0]   = 8'h2D;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_ab", 32'({a_v[0], b_v[0]}), 32'h2);
        check("mid_resp", 32'(resp_v[0]), 32'h0D);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ab", 32'({a_v[0], b_v[0]}), 32'd0);
        check("arst_busy", 32'(busy_v[0]), 32'd0);
        check("arst_resp", 32'(resp_v[0]), 32'd0);
        @(posedge clk); #1;
        check("arst_done", 32'(done_v[0]), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", 32'(done_v[0]), 32'd0);
        run(0, 3'd4, 8'h2D, 1'b0);

`ifdef Q2_STIM_CHECK_EN
        zkill[0] = 1'b1;
        run(0, 3'd4, 8'h2D, 1'b0);
        zkill[0] = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
